// File: rtl/mem_lsu.sv
// mem_lsu: RV32 load/store unit with a four-state FSM driving a single-port RAM.
// Ports: clk/reset_n; core req_i/we_i/funct3_i/addr_i/wdata_i -> ready_o/done_o/fault_o/rdata_o;
// RAM ram_en_o/ram_addr_o/ram_wdata_o/ram_wr_mask_o <- ram_rdata_i (one-cycle read latency).
module mem_lsu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rdata_o,
  output logic        ram_en_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wr_mask_o,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    LOAD_WAIT,
    DONE
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        done_q;
  logic        fault_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        ram_en_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [3:0]  ram_mask_q;

  logic        unsup_d;
  logic        fault_d;
  logic [3:0]  mask_d;
  logic [31:0] lane_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;

  // Request classification on the incoming (not yet latched) request.
  always_comb begin
    unsup_d = 1'b0;
    if (we_i) begin
      unsup_d = (funct3_i > 3'd2);
    end else begin
      unsup_d = (funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11);
    end
    fault_d = unsup_d
            || ((funct3_i[1:0] == 2'b01) && addr_i[0])
            || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  end

  // Store lanes: data replicated across the word, mask picks the lane.
  always_comb begin
    mask_d = 4'b1111;
    lane_d = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        mask_d = 4'b0001 << addr_i[1:0];
        lane_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        mask_d = addr_i[1] ? 4'b1100 : 4'b0011;
        lane_d = {2{wdata_i[15:0]}};
      end
      default: begin
        mask_d = 4'b1111;
        lane_d = wdata_i;
      end
    endcase
  end

  // Load extraction from the RAM word returned during LOAD_WAIT.
  always_comb begin
    byte_d = ram_rdata_i[7:0];
    case (off_q)
      2'd0: byte_d = ram_rdata_i[7:0];
      2'd1: byte_d = ram_rdata_i[15:8];
      2'd2: byte_d = ram_rdata_i[23:16];
      default: byte_d = ram_rdata_i[31:24];
    endcase
    half_d = off_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    load_d = ram_rdata_i;
    case (f3_q)
      3'b000: load_d = {{24{byte_d[7]}}, byte_d};
      3'b001: load_d = {{16{half_d[15]}}, half_d};
      3'b100: load_d = {24'h0, byte_d};
      3'b101: load_d = {16'h0, half_d};
      default: load_d = ram_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rdata_q     <= 32'h0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      ram_mask_q  <= 4'b0000;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            ready_q <= 1'b0;
            we_q    <= we_i;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            if (fault_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              ram_en_q    <= 1'b1;
              ram_addr_q  <= {addr_i[31:2], 2'b00};
              ram_wdata_q <= we_i ? lane_d : 32'h0;
              ram_mask_q  <= we_i ? mask_d : 4'b0000;
            end
          end
        end
        ACCESS: begin
          ram_en_q    <= 1'b0;
          ram_addr_q  <= 32'h0;
          ram_wdata_q <= 32'h0;
          ram_mask_q  <= 4'b0000;
          if (we_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          rdata_q <= load_d;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign rdata_o       = rdata_q;
  // Gate the RAM strobes with reset itself so an aborted access cannot write.
  assign ram_en_o      = ram_en_q & reset_n;
  assign ram_wr_mask_o = reset_n ? ram_mask_q : 4'b0000;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wdata_o   = ram_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed and random load/store sequence against a byte-level
// memory model, with a word RAM stand-in attached to the LSU RAM port.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] ram_rdata_i = 32'h0;
  logic        ready_o;
  logic        done_o;
  logic        fault_o;
  logic [31:0] rdata_o;
  logic        ram_en_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_wr_mask_o;

  int tests = 0;
  int failed = 0;

  logic [7:0]  ref_mem [64];
  logic [31:0] ref_rdata = 32'h0;
  logic [31:0] ram [16] = '{default: 32'h0};

  mem_lsu dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_i         (req_i),
    .we_i          (we_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .fault_o       (fault_o),
    .rdata_o       (rdata_o),
    .ram_en_o      (ram_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wdata_o   (ram_wdata_o),
    .ram_wr_mask_o (ram_wr_mask_o),
    .ram_rdata_i   (ram_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM stand-in: byte-masked write, registered read.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_wr_mask_o != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (ram_wr_mask_o[k]) begin
            ram[ram_addr_o[5:2]][8*k +: 8] <= ram_wdata_o[8*k +: 8];
          end
        end
      end else begin
        ram_rdata_i <= ram[ram_addr_o[5:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_fault(input logic we, input logic [2:0] f3,
                                     input int a);
    logic unsup;
    if (we) unsup = (f3 > 3'd2);
    else unsup = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (unsup) return 1'b1;
    if (f3[1:0] == 2'b01) return (a % 2) != 0;
    if (f3[1:0] == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Starts and ends on a negedge with the LSU idle.
  task automatic op(input logic we, input logic [2:0] f3, input int a,
                    input logic [31:0] wd);
    int lat = 0;
    int en_n = 0;
    bit seen = 0;
    logic f = 1'b0;
    logic [31:0] rd = 32'h0;
    logic [31:0] cap_a = 32'h0;
    logic [31:0] cap_w = 32'h0;
    logic [3:0] cap_m = 4'b0;
    logic ef;
    int n;
    logic [31:0] u;
    logic [31:0] lane;
    logic [31:0] mexp;
    chk("ready_idle", {31'h0, ready_o}, 32'h1);
    req_i = 1'b1;
    we_i = we;
    funct3_i = f3;
    addr_i = a;
    wdata_i = wd;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    we_i = 1'($urandom);
    funct3_i = 3'($urandom);
    addr_i = $urandom;
    wdata_i = $urandom;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (ram_en_o) begin
        en_n++;
        cap_a = ram_addr_o;
        cap_w = ram_wdata_o;
        cap_m = ram_wr_mask_o;
      end
      if (done_o) begin
        seen = 1;
        f = fault_o;
        rd = rdata_o;
      end
    end
    ef = exp_fault(we, f3, a);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    chk("latency", lat, ef ? 1 : (we ? 2 : 3));
    chk("fault", {31'h0, f}, {31'h0, ef});
    chk("ram_en_cycles", en_n, ef ? 0 : 1);
    if (!ef) begin
      chk("ram_addr", cap_a, 32'(a) & ~32'h3);
      mexp = we ? (((32'h1 << n) - 1) << (a % 4)) : 32'h0;
      chk("ram_mask", {28'h0, cap_m}, mexp);
      if (we) begin
        lane = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        chk("ram_wdata", cap_w, lane);
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'(wd >> (8 * k));
      end else begin
        u = 32'h0;
        for (int k = 0; k < n; k++) u = u | (32'(ref_mem[a + k]) << (8 * k));
        if (f3 == 3'd0 && u > 127) u = u - 32'd256;
        if (f3 == 3'd1 && u > 32767) u = u - 32'd65536;
        ref_rdata = u;
      end
    end
    chk("rdata", rd, ref_rdata);
    @(negedge clk);
    chk("done_one_cycle", {31'h0, done_o}, 32'h0);
  endtask

  initial begin
    int dn;
    int en;
    logic [31:0] v1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_ram_en", {31'h0, ram_en_o}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, ready_o}, 32'h1);
    chk("post_rst_done", {31'h0, done_o}, 32'h0);
    chk("post_rst_fault", {31'h0, fault_o}, 32'h0);

    // Directed vectors
    op(1'b1, 3'b010, 0, 32'habcdef89);
    op(1'b1, 3'b000, 3, 32'h000000ff);
    op(1'b0, 3'b010, 0, 32'h0);
    chk("lw_after_sb", rdata_o, 32'hffcdef89);
    op(1'b0, 3'b000, 3, 32'h0);
    chk("lb_3", rdata_o, 32'hffffffff);
    op(1'b0, 3'b100, 3, 32'h0);
    chk("lbu_3", rdata_o, 32'h000000ff);
    op(1'b0, 3'b001, 2, 32'h0);
    chk("lh_2", rdata_o, 32'hffffffcd);
    op(1'b0, 3'b101, 0, 32'h0);
    chk("lhu_0", rdata_o, 32'h0000ef89);
    op(1'b0, 3'b010, 6, 32'h0);
    op(1'b1, 3'b001, 1, 32'h12345678);
    op(1'b0, 3'b011, 0, 32'h0);
    op(1'b1, 3'b100, 0, 32'h11111111);
    chk("rdata_kept", rdata_o, 32'h0000ef89);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         $urandom_range(0, 60), $urandom);
    end

    // req_i held high: a store every three cycles
    req_i = 1'b1;
    we_i = 1'b1;
    funct3_i = 3'b010;
    addr_i = 32'd16;
    wdata_i = 32'h5a5aa5a5;
    dn = 0;
    en = 0;
    repeat (12) begin
      @(negedge clk);
      dn += int'(done_o);
      en += int'(ram_en_o);
    end
    req_i = 1'b0;
    chk("b2b_done", dn, 4);
    chk("b2b_en", en, 4);
    for (int k = 0; k < 4; k++) ref_mem[16 + k] = 8'(32'h5a5aa5a5 >> (8 * k));
    @(negedge clk);
    op(1'b0, 3'b010, 16, 32'h0);

    // Reset during the ACCESS cycle of a store
    v1 = $urandom;
    op(1'b1, 3'b010, 8, v1);
    req_i = 1'b1;
    we_i = 1'b1;
    funct3_i = 3'b010;
    addr_i = 32'd8;
    wdata_i = ~v1;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_ram_en", {31'h0, ram_en_o}, 32'h0);
    chk("abort_mask", {28'h0, ram_wr_mask_o}, 32'h0);
    @(negedge clk);
    chk("abort_done", {31'h0, done_o}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'h0, ready_o}, 32'h1);
    chk("rel_done", {31'h0, done_o}, 32'h0);
    chk("rel_fault", {31'h0, fault_o}, 32'h0);
    ref_rdata = 32'h0;
    chk("rel_rdata", rdata_o, ref_rdata);
    op(1'b0, 3'b010, 8, 32'h0);
    chk("no_write_on_abort", rdata_o, v1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
